seg7_result_display: RTL and testbench
======================================

// Module: seg7_result_display
// PURPOSE
//  Downstream display stage for the ALU calculator. Takes the 8-bit ALU result and overflow flag
//  through a valid/ready handshake and converts the magnitude to BCD with a sequential
//  shift-add-3 engine. It then time-multiplexes sign, digits and an overflow marker onto the
//  8-digit common-anode seven-segment display.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles per digit slot (1 kHz/digit at 100 MHz); min 2; counter width $clog2(REFRESH_DIV)
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  reset      in   1  synchronous, active-high reset
//  in_valid   in   1  result/overflow/is_signed are valid this cycle
//  in_ready   out  1  high when block can accept (converter idle)
//  result     in   8  ALU result
//  overflow   in   1  ALU overflow flag
//  is_signed  in   1  1: result is two's complement; 0: unsigned
//  conv_done  out  1  one-cycle pulse when new value committed to display
//  anode      out  8  digit enables, active-low, anode[0] = rightmost digit
//  cathode    out  7  segments, active-low, cathode = {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset
//  - FSM=IDLE; in_ready=1; conv_done=0; scan index=0; refresh counter=0.
//  - Display regs show "0": anode=8'hFE, cathode=7'b1000000.
//  Handshake
//  - Accept on a rising edge with in_valid&&in_ready; latch result, overflow, is_signed.
//  - in_valid while in_ready=0 is ignored, with no queueing. The source must hold the value.
//  FSM IDLE->CONV->COMMIT->IDLE
//  - Accept edge: ->CONV. mag = (is_signed && result[7]) ? -result : result, 8-bit unsigned.
//    So 8'h80 signed gives mag=128. neg = is_signed && result[7].
//  - CONV: exactly 8 cycles. Each cycle adds 3 to any BCD nibble >=5, then shifts left 1. Then ->COMMIT.
//  - COMMIT, 1 cycle: copies hundreds/tens/ones, neg and overflow into display regs,
//    pulses conv_done, ->IDLE.
//  - in_ready=0 from the accept edge until the COMMIT edge.
//  - Latency: display regs change on the 9th rising edge after the accept edge; in_ready=1 at that same edge.
//  - Old value stays displayed during conversion.
//  Digit map (slot: content)
//  - 0: ones, always lit.
//  - 1: tens; blank if hundreds==0 and tens==0.
//  - 2: hundreds; blank if 0.
//  - 3: '-' if neg, else blank.
//  - 4-6: always blank.
//  - 7: 'E' if overflow, else blank.
//  Segment patterns, active-low {g..a}
//  - '0' 1000000   '1' 1111001   '2' 0100100   '3' 0110000   '4' 0011001
//  - '5' 0010010   '6' 0000010   '7' 1111000   '8' 0000000   '9' 0010000
//  - '-' 0111111   'E' 0000110
//  Scan
//  - Refresh counter counts 0..REFRESH_DIV-1, then wraps; scan index += 1 mod 8 on wrap.
//  - anode/cathode are registered, updated one cycle after the index changes.
//  - Lit slot: anode = ~(1<<idx), cathode = pattern. Blank slot: anode=8'hFF, cathode=7'h7F.
//  - Never more than one anode low.
//  Boundary conditions
//  - Reset during CONV/COMMIT aborts the conversion, drops any partial result and returns to reset values.
//  - Reset wins over a simultaneous in_valid.
//  - Overflow is displayed as latched at accept, independent of the value.
// TESTING (bench uses REFRESH_DIV=4)
//  1. Assert reset 2 cycles -> anode=8'hFE, cathode=7'b1000000, in_ready=1, conv_done=0.
//  2. result=8'd100, is_signed=0, one-cycle valid -> conv_done on 9th edge.
//     Scan shows slot2 '1' 1111001, slot1 '0', slot0 '0'; slots 3-7 anode=8'hFF.
//  3. result=8'hF6, is_signed=1 -> slot3 '-', slot1 '1', slot0 '0', slot2 blank.
//     result=8'h80 signed -> '-','1','2','8'.
//  4. result=8'hFF unsigned -> '2','5','5', no '-'. result=8'd7 -> only slot0 lit, showing 1111000.
//  5. New valid 3 cycles after accept -> ignored, display keeps first value.
//     Reset at cycle 5 of CONV -> display returns to "0", no conv_done.
//  6. overflow=1 with result=8'd9 -> slot7 shows 'E' 0000110, slot0 '9'.
//     Next accept with overflow=0 -> slot7 blank.

Source files
------------

// File: rtl/seg7_result_display.sv
// rtl/seg7_result_display.sv - ALU result to 8-digit multiplexed seven-segment display
//
// Purpose:
//   Accepts an 8-bit ALU result plus overflow flag over a valid/ready
//   handshake and converts its magnitude to BCD with a sequential
//   shift-add-3 engine. It then scans the sign, the decimal digits and an
//   overflow marker across an 8-digit common-anode display.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high
//   in_valid   in   1  result/overflow/is_signed valid this cycle
//   in_ready   out  1  converter idle, input will be accepted
//   result     in   8  ALU result
//   overflow   in   1  ALU overflow flag
//   is_signed  in   1  1: result is two's complement, 0: unsigned
//   conv_done  out  1  one-cycle pulse when a new value reaches the display
//   anode      out  8  digit enables, active-low, anode[0] = rightmost
//   cathode    out  7  segments, active-low, {g,f,e,d,c,b,a}

module seg7_result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] result,
  input  logic       overflow,
  input  logic       is_signed,
  output logic       conv_done,
  output logic [7:0] anode,
  output logic [6:0] cathode
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CONV   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Conversion state
  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_bin;
  logic [11:0]   r_bcd;
  logic          r_neg;
  logic          r_ovf;
  logic          r_conv_done;

  // Committed display contents
  logic [3:0]    r_disp_hund;
  logic [3:0]    r_disp_tens;
  logic [3:0]    r_disp_ones;
  logic          r_disp_neg;
  logic          r_disp_ovf;

  // Scan state
  logic [CW-1:0] r_refresh;
  logic [2:0]    r_scan_idx;
  logic [7:0]    r_anode;
  logic [6:0]    r_cathode;

  logic          w_accept;
  logic          w_is_neg;
  logic [7:0]    w_mag;
  logic [11:0]   w_bcd_adj;
  logic [19:0]   w_shift;
  logic          w_slot_lit;
  logic [6:0]    w_slot_pat;
  logic [7:0]    w_anode_nxt;
  logic [6:0]    w_cathode_nxt;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'b1000000;
      4'd1:    seg_digit = 7'b1111001;
      4'd2:    seg_digit = 7'b0100100;
      4'd3:    seg_digit = 7'b0110000;
      4'd4:    seg_digit = 7'b0011001;
      4'd5:    seg_digit = 7'b0010010;
      4'd6:    seg_digit = 7'b0000010;
      4'd7:    seg_digit = 7'b1111000;
      4'd8:    seg_digit = 7'b0000000;
      4'd9:    seg_digit = 7'b0010000;
      default: seg_digit = 7'b1111111;
    endcase
  endfunction

  assign in_ready  = (r_state == ST_IDLE);
  assign conv_done = r_conv_done;
  assign anode     = r_anode;
  assign cathode   = r_cathode;

  assign w_accept = in_valid && in_ready;
  assign w_is_neg = is_signed && result[7];
  // 8'h80 negates to itself, which read as unsigned is the wanted 128.
  assign w_mag    = w_is_neg ? (8'd0 - result) : result;

  // One double-dabble step: correct every nibble >= 5, then shift the
  // BCD/binary pair left together so the binary MSB enters the ones digit.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int n = 0; n < 3; n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) begin
        w_bcd_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
      end
    end
    w_shift = {w_bcd_adj, r_bin} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_bin       <= 8'd0;
      r_bcd       <= 12'd0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_conv_done <= 1'b0;
      r_disp_hund <= 4'd0;
      r_disp_tens <= 4'd0;
      r_disp_ones <= 4'd0;
      r_disp_neg  <= 1'b0;
      r_disp_ovf  <= 1'b0;
    end else begin
      r_conv_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_bin     <= w_mag;
            r_bcd     <= 12'd0;
            r_neg     <= w_is_neg;
            r_ovf     <= overflow;
            r_bit_cnt <= 3'd0;
            r_state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_bcd     <= w_shift[19:8];
          r_bin     <= w_shift[7:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_disp_hund <= r_bcd[11:8];
          r_disp_tens <= r_bcd[7:4];
          r_disp_ones <= r_bcd[3:0];
          r_disp_neg  <= r_neg;
          r_disp_ovf  <= r_ovf;
          r_conv_done <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Slot content; leading zeros are suppressed but the ones digit always shows.
  always_comb begin
    w_slot_lit = 1'b0;
    w_slot_pat = SEG_BLANK;
    case (r_scan_idx)
      3'd0: begin
        w_slot_lit = 1'b1;
        w_slot_pat = seg_digit(r_disp_ones);
      end
      3'd1: begin
        w_slot_lit = (r_disp_hund != 4'd0) || (r_disp_tens != 4'd0);
        w_slot_pat = seg_digit(r_disp_tens);
      end
      3'd2: begin
        w_slot_lit = (r_disp_hund != 4'd0);
        w_slot_pat = seg_digit(r_disp_hund);
      end
      3'd3: begin
        w_slot_lit = r_disp_neg;
        w_slot_pat = SEG_DASH;
      end
      3'd7: begin
        w_slot_lit = r_disp_ovf;
        w_slot_pat = SEG_E;
      end
      default: begin
        w_slot_lit = 1'b0;
        w_slot_pat = SEG_BLANK;
      end
    endcase
    w_anode_nxt   = w_slot_lit ? ~(8'd1 << r_scan_idx) : 8'hFF;
    w_cathode_nxt = w_slot_lit ? w_slot_pat : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh  <= '0;
      r_scan_idx <= 3'd0;
      r_anode    <= 8'hFE;
      r_cathode  <= 7'b1000000;
    end else begin
      if (r_refresh == REFRESH_LAST) begin
        r_refresh  <= '0;
        r_scan_idx <= r_scan_idx + 3'd1;
      end else begin
        r_refresh <= r_refresh + 1'b1;
      end
      r_anode   <= w_anode_nxt;
      r_cathode <= w_cathode_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_result_display.sv
// tb/tb_seg7_result_display.sv - scoreboard bench for seg7_result_display
module tb_seg7_result_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] BL = 7'b1111111;

  typedef struct packed {
    logic [55:0] cat;
    logic [31:0] acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] result;
  logic       overflow;
  logic       is_signed;
  logic       conv_done;
  logic [7:0] anode;
  logic [6:0] cathode;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 0;
  exp_t        sb[$];

  seg7_result_display #(.REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .overflow(overflow), .is_signed(is_signed),
    .conv_done(conv_done), .anode(anode), .cathode(cathode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] mk(input logic [6:0] s7, input logic [6:0] s6,
                                     input logic [6:0] s5, input logic [6:0] s4,
                                     input logic [6:0] s3, input logic [6:0] s2,
                                     input logic [6:0] s1, input logic [6:0] s0);
    return {s7, s6, s5, s4, s3, s2, s1, s0};
  endfunction

  // Observe a full scan rotation and compare every slot to the expected digits.
  task automatic check_scan(input logic [55:0] ecat, input string tag);
    logic [7:0] seen;
    logic [6:0] got [8];
    logic [6:0] e;
    int bad_blank;
    int bad_multi;
    seen = 8'h00;
    bad_blank = 0;
    bad_multi = 0;
    for (int i = 0; i < 8; i++) got[i] = BL;
    repeat (40) begin
      @(negedge clk);
      if (anode == 8'hFF) begin
        if (cathode !== BL) bad_blank++;
      end else if ($onehot(~anode)) begin
        for (int i = 0; i < 8; i++) begin
          if (!anode[i]) begin
            seen[i] = 1'b1;
            got[i]  = cathode;
          end
        end
      end else begin
        bad_multi++;
      end
    end
    check($sformatf("%s blank_cathode", tag), bad_blank, 0);
    check($sformatf("%s one_anode", tag), bad_multi, 0);
    for (int i = 0; i < 8; i++) begin
      e = ecat[7*i +: 7];
      check($sformatf("%s slot%0d lit", tag, i), seen[i], (e != BL));
      if (e != BL) check($sformatf("%s slot%0d cathode", tag, i), got[i], e);
    end
  endtask

  task automatic send(input logic [7:0] r, input logic ov, input logic sg,
                      input logic [55:0] ecat, input logic push);
    exp_t x;
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", in_ready, 1'b1);
    in_valid  = 1'b1;
    result    = r;
    overflow  = ov;
    is_signed = sg;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x.cat = ecat;
    x.acc = cyc;
    if (push) sb.push_back(x);
    check("busy_after_accept", in_ready, 1'b0);
  endtask

  // Monitor: every conv_done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (conv_done === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_conv_done: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check("latency", cyc, e.acc + 32'd9);
          check("ready_at_commit", in_ready, 1'b1);
          @(negedge clk);
          check_scan(e.cat, "scan");
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    reset = 1'b1;
    in_valid = 1'b0;
    result = 8'd0;
    overflow = 1'b0;
    is_signed = 1'b0;
    repeat (2) @(negedge clk);
    check("rst anode", anode, 8'hFE);
    check("rst cathode", cathode, S0);
    check("rst in_ready", in_ready, 1'b1);
    check("rst conv_done", conv_done, 1'b0);
    reset = 1'b0;
    check_scan(mk(BL, BL, BL, BL, BL, BL, BL, S0), "rst_scan");

    send(8'd100, 1'b0, 1'b0, mk(BL, BL, BL, BL, BL, S1, S0, S0), 1'b1);
    repeat (70) @(negedge clk);
    send(8'hF6, 1'b0, 1'b1, mk(BL, BL, BL, BL, SD, BL, S1, S0), 1'b1);
    repeat (70) @(negedge clk);
    send(8'h80, 1'b0, 1'b1, mk(BL, BL, BL, BL, SD, S1, S2, S8), 1'b1);
    repeat (70) @(negedge clk);
    send(8'hFF, 1'b0, 1'b0, mk(BL, BL, BL, BL, BL, S2, S5, S5), 1'b1);
    repeat (70) @(negedge clk);
    send(8'd7, 1'b0, 1'b0, mk(BL, BL, BL, BL, BL, BL, BL, S7), 1'b1);
    repeat (70) @(negedge clk);
    send(8'd105, 1'b0, 1'b0, mk(BL, BL, BL, BL, BL, S1, S0, S5), 1'b1);
    repeat (70) @(negedge clk);

    // Second valid while busy must be dropped.
    send(8'd55, 1'b0, 1'b0, mk(BL, BL, BL, BL, BL, BL, S5, S5), 1'b1);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    result = 8'd99;
    check("busy_ignore in_ready", in_ready, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (70) @(negedge clk);

    // Reset during CONV aborts: no commit, display back to "0".
    send(8'd200, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("abort anode", anode, 8'hFE);
    check("abort cathode", cathode, S0);
    check("abort in_ready", in_ready, 1'b1);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (conv_done) pulses++;
    end
    check("abort no conv_done", pulses, 0);
    check_scan(mk(BL, BL, BL, BL, BL, BL, BL, S0), "abort_scan");

    send(8'd9, 1'b1, 1'b0, mk(SE, BL, BL, BL, BL, BL, BL, S9), 1'b1);
    repeat (70) @(negedge clk);
    send(8'h2A, 1'b0, 1'b1, mk(BL, BL, BL, BL, BL, BL, S4, S2), 1'b1);
    repeat (70) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
